tdc_phase_sweep_ctrl: RTL and testbench
=======================================

Name: tdc_phase_sweep_ctrl

Overview:
Sequencer for the carry-chain TDC phase-sweep experiment. It drives the dynamic PLL phase-step handshake (phase_en/phase_done), waits for the shifted clock to settle, samples the carry-chain thermometer code and computes its ones-count. Each result is written to response RAM at one address per phase step. It sits between the PLL_Dynamic instance, the CarryChain output register and a RAM_response instance, all in the clock domain.

Parameters:
N_STEPS, 8, number of phase steps per sweep (>=2); STEP_W = $clog2(N_STEPS)
N_BITS, 16, carry-chain thermometer width; CNT_W = $clog2(N_BITS+1)
MIN_EN, 2, minimum cycles phase_en is held high (>=2)
SETTLE_CYCLES, 4, wait cycles after phase_done returns high (>=1)
TIMEOUT, 255, maximum cycles spent waiting on any phase_done edge or on locked
CNTSEL, 5'b00000, PLL counter select driven on cntsel

Ports:
clock  in  1  controller clock; all logic on posedge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse that begins a sweep; accepted in IDLE, DONE and ERROR
abort  in  1  level; synchronous return to IDLE from any state
updn_in  in  1  sweep direction, sampled on start
locked  in  1  PLL lock (asynchronous; 2-FF synchronised internally)
phase_done  in  1  PLL phase-done (asynchronous; 2-FF synchronised internally)
tdc_code  in  N_BITS  registered carry-chain sum
phase_en  out  1  PLL phase-step enable
updn  out  1  latched direction
cntsel  out  5  constant CNTSEL
busy  out  1  high in every state except IDLE, DONE and ERROR
done  out  1  high in DONE
error  out  1  high in ERROR
err_code  out  2  00 none, 01 lock timeout, 10 phase_done timeout, 11 lock lost
step  out  STEP_W  current step index
wr_en  out  1  one-cycle RAM write strobe
wr_addr  out  STEP_W  RAM address (= step)
wr_data  out  CNT_W+N_BITS  {ones_count, code}

Behaviour:
- Reset: all outputs 0; state IDLE; synchroniser flops 0; cntsel = CNTSEL.
- States: IDLE, WAIT_LOCK, PH_EN, WAIT_HI, SETTLE, CAPTURE, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR + start: latch updn <= updn_in; step <= 0; clear done, error, err_code; go to WAIT_LOCK.
- WAIT_LOCK: locked_s = 1 -> PH_EN. After TIMEOUT cycles without lock -> ERROR, err_code 01.
- PH_EN: phase_en = 1; en_cnt increments each cycle.
  - Exit when en_cnt >= MIN_EN-1 AND phase_done_s = 0: phase_en deasserts on the same edge as the state change to WAIT_HI.
  - TIMEOUT cycles without that condition -> ERROR, err_code 10.
- WAIT_HI: phase_en = 0. phase_done_s = 1 -> SETTLE. TIMEOUT -> ERROR, err_code 10.
- SETTLE: hold SETTLE_CYCLES cycles, then go to CAPTURE.
- CAPTURE: one cycle; register tdc_code and its popcount (count of ones, not the thermometer edge, so bubbles are tolerated). Popcount range is 0..N_BITS.
- WRITE: wr_en = 1 for exactly one cycle; wr_addr = step; wr_data = {count, code}.
  - If step = N_STEPS-1 -> DONE.
  - Otherwise step <= step+1 and go to PH_EN. There is no second lock check between steps.
- Lock lost: locked_s = 0 in any of PH_EN, WAIT_HI, SETTLE, CAPTURE or WRITE -> ERROR, err_code 11, phase_en = 0. A WRITE in progress in that cycle is suppressed: wr_en = 0.
- Timeout counter clears on every state change.
- abort has priority over everything except reset: next state IDLE, phase_en = 0, wr_en = 0, step <= 0.
- start while busy is ignored.
- start and abort in the same cycle: abort wins.
- Reset asserted mid-sweep returns asynchronously to IDLE with all outputs 0. No partial write occurs, because wr_en is cleared asynchronously.
- ERROR and DONE are sticky until the next start or abort.
- Latency per step, with ideal PLL responses: 2 (synchroniser) + MIN_EN + phase_done low/high round trip + SETTLE_CYCLES + 2 cycles.

Test Plan:
- Nominal sweep: locked = 1, PLL model drops phase_done 3 cycles after phase_en rises and raises it 4 cycles later, tdc_code = 16'h00FF -> 8 writes at addr 0..7, each wr_data = {5'd8, 16'h00FF}; done = 1; phase_en shows exactly 8 pulses, each >= 2 cycles wide.
- Popcount boundaries: tdc_code = 16'h0000, then 16'hFFFF, then 16'h0F0F (bubble) at steps 0, 1, 2 -> counts 0, 16 and 8.
- Lock never asserted: start with locked = 0 -> after 255 cycles error = 1, err_code = 01, no wr_en, phase_en never high.
- phase_done stuck high: start with locked = 1 -> phase_en held high for 255 cycles, then error = 1, err_code = 10, phase_en = 0.
- Lock dropped during SETTLE of step 3 -> error = 1, err_code = 11; only addresses 0..2 written.
- Mid-sweep abort at step 5, and separately reset pulled low at step 5 -> IDLE with step = 0 and all outputs 0; a following start reruns the full 8-step sweep with updn taken from the new updn_in.

Source files
------------

// File: rtl/tdc_phase_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tdc_phase_sweep_ctrl
//
// Sequencer for the carry-chain TDC phase-sweep experiment. For each of
// N_STEPS phase steps it pulses the PLL dynamic phase-step handshake, waits
// for phase_done to go low and back high, lets the shifted clock settle,
// captures the carry-chain thermometer code with its ones-count and writes
// {count, code} to the response RAM at address = step.
//
// Ports
//   clock       controller clock, all logic on posedge
//   reset       asynchronous active-low reset
//   start       single-cycle sweep start (accepted in IDLE / DONE / ERROR)
//   abort       level, synchronous return to IDLE from any state
//   updn_in     sweep direction, latched on start
//   locked      PLL lock, asynchronous, synchronised internally
//   phase_done  PLL phase-done, asynchronous, synchronised internally
//   tdc_code    registered carry-chain thermometer code
//   phase_en    PLL phase-step enable
//   updn        latched sweep direction
//   cntsel      PLL counter select (constant CNTSEL)
//   busy        sweep in progress
//   done        sweep completed (sticky)
//   error       sweep failed (sticky)
//   err_code    00 none, 01 lock timeout, 10 phase_done timeout, 11 lock lost
//   step        current step index
//   wr_en       one-cycle response RAM write strobe
//   wr_addr     response RAM address
//   wr_data     {ones_count, code}
// ---------------------------------------------------------------------------
module tdc_phase_sweep_ctrl #(
    parameter int          N_STEPS       = 8,
    parameter int          N_BITS        = 16,
    parameter int          MIN_EN        = 2,
    parameter int          SETTLE_CYCLES = 4,
    parameter int          TIMEOUT       = 255,
    parameter logic [4:0]  CNTSEL        = 5'b00000,
    localparam int         STEP_W        = $clog2(N_STEPS),
    localparam int         CNT_W         = $clog2(N_BITS + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    updn_in,
    input  logic                    locked,
    input  logic                    phase_done,
    input  logic [N_BITS-1:0]       tdc_code,
    output logic                    phase_en,
    output logic                    updn,
    output logic [4:0]              cntsel,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [STEP_W-1:0]       step,
    output logic                    wr_en,
    output logic [STEP_W-1:0]       wr_addr,
    output logic [CNT_W+N_BITS-1:0] wr_data
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int EN_W  = $clog2(MIN_EN) + 1;

    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  SETTLE_LAST = TMO_W'(SETTLE_CYCLES - 1);
    localparam logic [EN_W-1:0]   EN_LAST     = EN_W'(MIN_EN - 1);
    localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(N_STEPS - 1);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_LOCK_TMO = 2'b01;
    localparam logic [1:0] ERR_PD_TMO   = 2'b10;
    localparam logic [1:0] ERR_LOCKLOST = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_LOCK,
        PH_EN,
        WAIT_HI,
        SETTLE,
        CAPTURE,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t            state;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [EN_W-1:0]   en_cnt;

    // Two-flop synchronisers: _p0 is the metastability-catching flop,
    // _p1 is the clean synchronised value.
    logic lk_p0, lk_p1;
    logic pd_p0, pd_p1;

    logic locked_s;
    logic phase_done_s;
    logic lock_lost;

    // Ones-count rather than edge position, so bubbles in the thermometer
    // code still give a meaningful result.
    function automatic logic [CNT_W-1:0] popcount(input logic [N_BITS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_BITS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // ---- stage p0/p1: input synchronisers ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lk_p0 <= 1'b0;
            lk_p1 <= 1'b0;
            pd_p0 <= 1'b0;
            pd_p1 <= 1'b0;
        end else begin
            lk_p0 <= locked;
            lk_p1 <= lk_p0;
            pd_p0 <= phase_done;
            pd_p1 <= pd_p0;
        end
    end

    assign locked_s     = lk_p1;
    assign phase_done_s = pd_p1;

    assign lock_lost = !locked_s &&
                       ((state == PH_EN)   || (state == WAIT_HI) ||
                        (state == SETTLE)  || (state == CAPTURE) ||
                        (state == WRITE));

    assign busy   = (state != IDLE) && (state != DONE) && (state != ERROR);
    assign cntsel = CNTSEL;

    // ---- sequencer ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tmo_cnt  <= '0;
            en_cnt   <= '0;
            phase_en <= 1'b0;
            updn     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            step     <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (tmo_cnt != '1) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (abort) begin
                state    <= IDLE;
                tmo_cnt  <= '0;
                en_cnt   <= '0;
                phase_en <= 1'b0;
                updn     <= 1'b0;
                done     <= 1'b0;
                error    <= 1'b0;
                err_code <= ERR_NONE;
                step     <= '0;
                wr_addr  <= '0;
                wr_data  <= '0;
            end else if (lock_lost) begin
                state    <= ERROR;
                tmo_cnt  <= '0;
                phase_en <= 1'b0;
                error    <= 1'b1;
                err_code <= ERR_LOCKLOST;
            end else begin
                case (state)
                    IDLE, DONE, ERROR: begin
                        if (start) begin
                            state    <= WAIT_LOCK;
                            tmo_cnt  <= '0;
                            updn     <= updn_in;
                            step     <= '0;
                            done     <= 1'b0;
                            error    <= 1'b0;
                            err_code <= ERR_NONE;
                        end
                    end

                    WAIT_LOCK: begin
                        if (locked_s) begin
                            state    <= PH_EN;
                            tmo_cnt  <= '0;
                            en_cnt   <= '0;
                            phase_en <= 1'b1;
                        end else if (tmo_cnt == TMO_LAST) begin
                            state    <= ERROR;
                            tmo_cnt  <= '0;
                            error    <= 1'b1;
                            err_code <= ERR_LOCK_TMO;
                        end
                    end

                    PH_EN: begin
                        if (en_cnt < EN_LAST) begin
                            en_cnt <= en_cnt + 1'b1;
                        end
                        // phase_en drops on the same edge that leaves PH_EN,
                        // so its width is exactly the time spent here.
                        if ((en_cnt >= EN_LAST) && !phase_done_s) begin
                            state    <= WAIT_HI;
                            tmo_cnt  <= '0;
                            phase_en <= 1'b0;
                        end else if (tmo_cnt == TMO_LAST) begin
                            state    <= ERROR;
                            tmo_cnt  <= '0;
                            phase_en <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_PD_TMO;
                        end
                    end

                    WAIT_HI: begin
                        if (phase_done_s) begin
                            state   <= SETTLE;
                            tmo_cnt <= '0;
                        end else if (tmo_cnt == TMO_LAST) begin
                            state    <= ERROR;
                            tmo_cnt  <= '0;
                            error    <= 1'b1;
                            err_code <= ERR_PD_TMO;
                        end
                    end

                    SETTLE: begin
                        if (tmo_cnt == SETTLE_LAST) begin
                            state   <= CAPTURE;
                            tmo_cnt <= '0;
                        end
                    end

                    CAPTURE: begin
                        state   <= WRITE;
                        tmo_cnt <= '0;
                        wr_addr <= step;
                        wr_data <= {popcount(tdc_code), tdc_code};
                        // lk_p0 is what locked_s will be during WRITE, so a
                        // lock loss seen in WRITE never produces a strobe.
                        wr_en   <= lk_p0;
                    end

                    WRITE: begin
                        tmo_cnt <= '0;
                        if (step == STEP_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= PH_EN;
                            step     <= step + 1'b1;
                            en_cnt   <= '0;
                            phase_en <= 1'b1;
                        end
                    end

                    default: begin
                        state    <= IDLE;
                        tmo_cnt  <= '0;
                        phase_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdc_phase_sweep_ctrl.sv
module tb_tdc_phase_sweep_ctrl;

    localparam int STEP_W = 3;
    localparam int CNT_W  = 5;
    localparam int N_BITS = 16;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    start;
    logic                    abort;
    logic                    updn_in;
    logic                    locked;
    logic                    phase_done = 1'b1;
    logic [N_BITS-1:0]       tdc_code;
    logic                    phase_en;
    logic                    updn;
    logic [4:0]              cntsel;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic [1:0]              err_code;
    logic [STEP_W-1:0]       step;
    logic                    wr_en;
    logic [STEP_W-1:0]       wr_addr;
    logic [CNT_W+N_BITS-1:0] wr_data;

    int total = 0;
    int bad   = 0;

    logic [N_BITS-1:0]       code_tab [8];
    logic [STEP_W-1:0]       addr_log [16];
    logic [CNT_W+N_BITS-1:0] data_log [16];
    int nw;
    int pulses;
    int minw;
    int curw;
    logic pe_d;

    logic pd_stuck = 1'b0;
    int   pt = -1;
    logic en_seen = 1'b0;

    tdc_phase_sweep_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .updn_in    (updn_in),
        .locked     (locked),
        .phase_done (phase_done),
        .tdc_code   (tdc_code),
        .phase_en   (phase_en),
        .updn       (updn),
        .cntsel     (cntsel),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .step       (step),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    always #5 clock = ~clock;

    always_comb tdc_code = code_tab[step];

    // PLL model: phase_done drops 3 cycles after phase_en rises, returns 4 later.
    always @(posedge clock) begin
        #1;
        if (pd_stuck) begin
            phase_done = 1'b1;
            pt = -1;
        end else begin
            if (phase_en && !en_seen && pt < 0) pt = 0;
            else if (pt >= 0) pt = pt + 1;
            if (pt == 3) phase_done = 1'b0;
            if (pt == 7) begin
                phase_done = 1'b1;
                pt = -1;
            end
        end
        en_seen = phase_en;
    end

    // Write and phase_en pulse monitor.
    always @(negedge clock) begin
        if (wr_en) begin
            if (nw < 16) begin
                addr_log[nw] = wr_addr;
                data_log[nw] = wr_data;
            end
            nw = nw + 1;
        end
        if (phase_en) curw = curw + 1;
        if (phase_en && !pe_d) pulses = pulses + 1;
        if (!phase_en && pe_d) begin
            if (curw < minw) minw = curw;
            curw = 0;
        end
        pe_d = phase_en;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        @(posedge clock);
        #2;
        nw = 0;
        pulses = 0;
        minw = 9999;
        curw = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic start_sweep(input logic d);
        @(negedge clock);
        start = 1'b1;
        updn_in = d;
        @(posedge clock);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int lim);
        int n;
        n = 0;
        while (!(done || error) && n < lim) begin
            @(posedge clock);
            #2;
            n++;
        end
        check(tag, 64'(n < lim), 64'd1);
    endtask

    task automatic wait_writes(input string tag, input int k, input int lim);
        int n;
        n = 0;
        while (nw < k && n < lim) begin
            @(posedge clock);
            #2;
            n++;
        end
        check(tag, 64'(n < lim), 64'd1);
    endtask

    function automatic logic [63:0] all_out();
        return 64'({phase_en, updn, busy, done, error, err_code, step, wr_en, wr_addr, wr_data});
    endfunction

    initial begin
        int n;
        int enc;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        updn_in = 1'b0;
        locked = 1'b1;
        for (int i = 0; i < 8; i++) code_tab[i] = 16'h00FF;
        nw = 0; pulses = 0; minw = 9999; curw = 0; pe_d = 1'b0;

        // Reset state
        idle(3);
        check("rst_outputs", all_out(), 64'd0);
        check("rst_cntsel", 64'(cntsel), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        idle(4);

        // Nominal sweep
        clr_mon();
        start_sweep(1'b1);
        check("nom_busy", 64'(busy), 64'd1);
        check("nom_updn", 64'(updn), 64'd1);
        wait_end("nom_wait", 1000);
        check("nom_done", 64'(done), 64'd1);
        check("nom_error", 64'(error), 64'd0);
        check("nom_nwrites", 64'(nw), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("nom_addr%0d", i), 64'(addr_log[i]), 64'(i));
            check($sformatf("nom_data%0d", i), 64'(data_log[i]), 64'({5'd8, 16'h00FF}));
        end
        check("nom_pulses", 64'(pulses), 64'd8);
        check("nom_minw_ge2", 64'(minw >= 2), 64'd1);
        check("nom_busy_end", 64'(busy), 64'd0);

        // Popcount boundaries, with a start pulse while busy that must be ignored
        code_tab[0] = 16'h0000;
        code_tab[1] = 16'hFFFF;
        code_tab[2] = 16'h0F0F;
        clr_mon();
        start_sweep(1'b0);
        wait_writes("pc_wait1", 1, 500);
        start_sweep(1'b1);
        wait_end("pc_wait", 1000);
        check("pc_done", 64'(done), 64'd1);
        check("pc_updn_kept", 64'(updn), 64'd0);
        check("pc_nwrites", 64'(nw), 64'd8);
        check("pc_addr2", 64'(addr_log[2]), 64'd2);
        check("pc_zero", 64'(data_log[0]), 64'({5'd0, 16'h0000}));
        check("pc_full", 64'(data_log[1]), 64'({5'd16, 16'hFFFF}));
        check("pc_bubble", 64'(data_log[2]), 64'({5'd8, 16'h0F0F}));
        for (int i = 0; i < 8; i++) code_tab[i] = 16'h00FF;

        // Lock never asserted
        locked = 1'b0;
        idle(5);
        clr_mon();
        start_sweep(1'b0);
        n = 0;
        while (!error && n < 400) begin
            @(posedge clock);
            #2;
            n++;
        end
        check("lk_tmo_cycles", 64'(n), 64'd255);
        check("lk_tmo_error", 64'(error), 64'd1);
        check("lk_tmo_code", 64'(err_code), 64'd1);
        check("lk_tmo_nowrite", 64'(nw), 64'd0);
        check("lk_tmo_noen", 64'(pulses), 64'd0);
        locked = 1'b1;
        idle(5);

        // phase_done stuck high
        pd_stuck = 1'b1;
        idle(3);
        clr_mon();
        start_sweep(1'b0);
        check("pd_tmo_clr_err", 64'(error), 64'd0);
        n = 0;
        enc = 0;
        while (!error && n < 400) begin
            @(posedge clock);
            #2;
            n++;
            if (phase_en) enc++;
        end
        check("pd_tmo_en_cycles", 64'(enc), 64'd255);
        check("pd_tmo_error", 64'(error), 64'd1);
        check("pd_tmo_code", 64'(err_code), 64'd2);
        check("pd_tmo_en_low", 64'(phase_en), 64'd0);
        pd_stuck = 1'b0;
        idle(5);

        // Lock dropped during SETTLE of step 3
        clr_mon();
        start_sweep(1'b0);
        wait_writes("ll_wait3", 3, 1000);
        n = 0;
        while (phase_done && n < 100) begin @(posedge clock); #2; n++; end
        while (!phase_done && n < 100) begin @(posedge clock); #2; n++; end
        check("ll_pd_seen", 64'(n < 100), 64'd1);
        @(posedge clock);
        #1;
        locked = 1'b0;
        idle(10);
        check("ll_error", 64'(error), 64'd1);
        check("ll_code", 64'(err_code), 64'd3);
        check("ll_en_low", 64'(phase_en), 64'd0);
        check("ll_nwrites", 64'(nw), 64'd3);
        check("ll_addr2", 64'(addr_log[2]), 64'd2);
        locked = 1'b1;
        idle(10);

        // Abort at step 5 together with start, then rerun with new direction
        clr_mon();
        start_sweep(1'b0);
        wait_writes("ab_wait5", 5, 1000);
        check("ab_step5", 64'(step), 64'd5);
        @(negedge clock);
        abort = 1'b1;
        start = 1'b1;
        updn_in = 1'b1;
        @(posedge clock);
        #2;
        abort = 1'b0;
        start = 1'b0;
        check("ab_outputs", all_out(), 64'd0);
        idle(12);
        clr_mon();
        start_sweep(1'b1);
        check("ab_updn_new", 64'(updn), 64'd1);
        wait_end("ab_wait", 1000);
        check("ab_rerun_done", 64'(done), 64'd1);
        check("ab_rerun_nw", 64'(nw), 64'd8);
        check("ab_rerun_addr7", 64'(addr_log[7]), 64'd7);

        // Asynchronous reset at step 5, then rerun
        clr_mon();
        start_sweep(1'b1);
        wait_writes("rs_wait5", 5, 1000);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("rs_outputs", all_out(), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        idle(12);
        clr_mon();
        start_sweep(1'b1);
        check("rs_updn_new", 64'(updn), 64'd1);
        wait_end("rs_wait", 1000);
        check("rs_rerun_done", 64'(done), 64'd1);
        check("rs_rerun_nw", 64'(nw), 64'd8);
        check("rs_rerun_data0", 64'(data_log[0]), 64'({5'd8, 16'h00FF}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
